ppc_branch_spr_unit: RTL

PPC_BRANCH_SPR_UNIT -- requirements
Module: ppc_branch_spr_unit

---
 rtl/ppc_branch_spr_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ppc_branch_spr_unit.sv
// Branch and special-purpose-register unit: resolves b/bc/bclr/bcctr,
// executes mtspr/mfspr on LR and CTR, and owns the condition register.
// One result register sits between the decode logic and the consumer.
module ppc_branch_spr_unit #(
  parameter int XLEN      = 64,
  parameter int CR_FIELDS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs_val,
  input  logic            cr_upd_valid,
  input  logic [XLEN-1:0] cr_upd_result,
  input  logic            cr_upd_so,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            redirect,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] rd_data,
  output logic            illegal
);

  localparam int CRW = 4 * CR_FIELDS;

  // CR is kept in the architectural big-endian numbering: cr_q[0] is CR0.LT.
  logic [0:CRW-1]  cr_q, cr_d;
  logic [XLEN-1:0] lr_q, lr_d, ctr_q, ctr_d;
  logic            out_valid_q, out_valid_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] target_q, target_d, rd_data_q, rd_data_d;
  logic            illegal_q, illegal_d;

  // Instruction fields; little-endian slices of the big-endian encoding.
  logic [5:0]  opcd;
  logic [4:0]  bo, bi;
  logic [9:0]  xo, spr;
  logic        aa, lk;
  assign opcd = inst[31:26];
  assign bo   = inst[25:21];
  assign bi   = inst[20:16];
  assign xo   = inst[10:1];
  assign aa   = inst[1];
  assign lk   = inst[0];
  assign spr  = {inst[15:11], inst[20:16]};

  logic is_b, is_bc, is_bclr, is_bcctr, is_mt, is_mf, is_br;
  logic spr_lr, spr_ctr, spr_ok, bi_ok, legal, acc;
  logic cr_bit, ctr_ok, cond_ok, taken;
  logic [XLEN-1:0] li_off, bd_off, ctr_m1, pc4, br_tgt;

  assign is_b     = opcd == 6'd18;
  assign is_bc    = opcd == 6'd16;
  assign is_bclr  = opcd == 6'd19 && xo == 10'd16;
  assign is_bcctr = opcd == 6'd19 && xo == 10'd528;
  assign is_mt    = opcd == 6'd31 && xo == 10'd467;
  assign is_mf    = opcd == 6'd31 && xo == 10'd339;
  assign is_br    = is_b | is_bc | is_bclr | is_bcctr;
  assign spr_lr   = spr == 10'd8;
  assign spr_ctr  = spr == 10'd9;
  assign spr_ok   = spr_lr | spr_ctr;
  assign bi_ok    = int'(bi) < CRW;

  // bcctr cannot decrement the register it branches through.
  assign legal = is_b
               | ((is_bc | is_bclr) & bi_ok)
               | (is_bcctr & bi_ok & bo[2])
               | ((is_mt | is_mf) & spr_ok);

  assign in_ready = !out_valid_q | out_ready;
  assign acc      = in_valid & in_ready;

  assign li_off = {{(XLEN-26){inst[25]}}, inst[25:2], 2'b00};
  assign bd_off = {{(XLEN-16){inst[15]}}, inst[15:2], 2'b00};
  assign ctr_m1 = ctr_q - {{(XLEN-1){1'b0}}, 1'b1};
  assign pc4    = pc + {{(XLEN-3){1'b0}}, 3'd4};

  // Select the CR bit named by BI (big-endian index).
  always_comb begin
    cr_bit = 1'b0;
    for (int i = 0; i < CRW; i++)
      if (i == int'(bi)) cr_bit = cr_q[i];
  end

  // BO[k] in architectural numbering is bo[4-k].
  assign ctr_ok  = bo[2] | ((ctr_m1 != '0) ^ bo[1]);
  assign cond_ok = bo[4] | (cr_bit == bo[3]);
  assign taken   = is_b | (ctr_ok & cond_ok);

  // Branch target; the not-taken case still reports the computed address.
  always_comb begin
    br_tgt = '0;
    if (is_b)          br_tgt = aa ? li_off : pc + li_off;
    else if (is_bc)    br_tgt = aa ? bd_off : pc + bd_off;
    else if (is_bclr)  br_tgt = {lr_q[XLEN-1:2], 2'b00};
    else if (is_bcctr) br_tgt = {ctr_q[XLEN-1:2], 2'b00};
  end

  // Next-state for the output register and LR/CTR/CR.
  always_comb begin
    out_valid_d = out_valid_q;
    redirect_d  = redirect_q;
    target_d    = target_q;
    rd_data_d   = rd_data_q;
    illegal_d   = illegal_q;
    lr_d        = lr_q;
    ctr_d       = ctr_q;
    cr_d        = cr_q;
    if (acc) begin
      out_valid_d = 1'b1;
      redirect_d  = 1'b0;
      target_d    = '0;
      rd_data_d   = '0;
      illegal_d   = !legal;
      if (legal) begin
        if (is_br) begin
          redirect_d = taken;
          target_d   = br_tgt;
          if (lk) lr_d = pc4;
          if ((is_bc | is_bclr) & !bo[2]) ctr_d = ctr_m1;
        end else if (is_mt) begin
          if (spr_lr) lr_d = rs_val;
          else        ctr_d = rs_val;
        end else begin
          rd_data_d = spr_lr ? lr_q : ctr_q;
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A same-cycle branch has already sampled the old cr_q above.
    if (cr_upd_valid) begin
      cr_d[0] = cr_upd_result[XLEN-1];
      cr_d[1] = !cr_upd_result[XLEN-1] && (cr_upd_result != '0);
      cr_d[2] = cr_upd_result == '0;
      cr_d[3] = cr_upd_so;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      redirect_q  <= 1'b0;
      target_q    <= '0;
      rd_data_q   <= '0;
      illegal_q   <= 1'b0;
      lr_q        <= '0;
      ctr_q       <= '0;
      cr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      redirect_q  <= redirect_d;
      target_q    <= target_d;
      rd_data_q   <= rd_data_d;
      illegal_q   <= illegal_d;
      lr_q        <= lr_d;
      ctr_q       <= ctr_d;
      cr_q        <= cr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign redirect  = redirect_q;
  assign target    = target_q;
  assign rd_data   = rd_data_q;
  assign illegal   = illegal_q;

endmodule
